irst_sequencer: RTL
===================

Name: irst_sequencer

Overview:
- Run controller for the instruction-fetch fault-injection (IRST) logic. Holds the host-written IRST configuration, arms and disarms the fetch stage's `irst_reg_data` word, and sources `rand_data` from an LFSR.
- Counts run and MIS (memory-inject) cycles, enforces a timeout, and handles abort.
- When the fetch stage cannot leave a run on its own, the block pulses the fetch stage's active-high reset.
- Sits between the host/debug register port and IF_stage.

Parameters:
- SEED_DEFAULT, 16'hACE1, reset value of the LFSR seed register (also substituted when seed 0 is written).
- TIMEOUT_DEFAULT, 16'd0, reset value of the timeout register; 0 = timeout disabled.
- RECOVER_CYCLES, 2, number of cycles `if_rst` is held high.
- DRAIN_MAX, 8, maximum DRAIN cycles before escalating to RECOVER.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cfg_wr_en  in  1  host register write strobe
- cfg_addr  in  2  0=config, 1=seed, 2=timeout, 3=command
- cfg_wdata  in  16  write data
- irst_done  in  1  IF_stage DONE indication
- write_en  in  1  IF_stage MIS indication
- irst_reg_data  out  16  {enable, pc_limit[6:0], freq[1:0], count[5:0]} to IF_stage
- rand_data  out  3  lfsr[2:0] to IF_stage
- if_rst  out  1  active-high reset request to IF_stage
- busy  out  1  state != IDLE
- result  out  2  00 none, 01 pass, 10 timeout, 11 abort
- run_cycles  out  16  cycles spent in RUN, saturating
- mis_cycles  out  16  RUN cycles with `write_en`=1, saturating
- irq  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (`rst`=0, async) values:
  - State, outputs and registers: state=IDLE, cfg=0, timeout=TIMEOUT_DEFAULT, lfsr=SEED_DEFAULT.
  - Outputs: `irst_reg_data`=0, `rand_data`=SEED_DEFAULT[2:0], `if_rst`=0, `busy`=0, `result`=0, counters=0, `irq`=0.
- Register writes:
  - Addresses 0-2 are accepted only in IDLE; otherwise they are dropped silently.
  - Config stores `cfg_wdata[14:0]`; bit 15 is ignored.
  - A seed write of 0 stores SEED_DEFAULT.
- Command (addr 3):
  - bit0 start is honoured only in IDLE.
  - bit1 abort is honoured only in ARM or RUN.
  - Start and abort in the same write: abort wins, no start.
- `irst_reg_data[15]` (enable) is 1 only in ARM and RUN. Bits [14:0] always equal cfg.
- FSM states: IDLE, ARM, RUN, DRAIN, RECOVER.
- IDLE:
  - enable=0.
  - start -> ARM next cycle.
- ARM (exactly 1 cycle):
  - Clear counters and `result`.
  - Load lfsr from the seed register.
  - Next state is RUN, or RECOVER with `result`=11 if abort is written in this cycle.
- RUN: every cycle, `run_cycles`+=1 (saturate at 16'hFFFF) and `mis_cycles`+=`write_en`. Exits, evaluated in this priority order:
  1. `irst_done`=1 -> `result`=01, go to DRAIN.
  2. Abort -> `result`=11, go to RECOVER.
  3. `timeout`!=0 and `run_cycles`==`timeout`-1 (i.e. `timeout` RUN cycles elapsed) -> `result`=10, go to RECOVER.
- DRAIN:
  - enable=0.
  - Wait for `irst_done`=0, then go to IDLE with `irq`.
  - If `irst_done` is still 1 after DRAIN_MAX cycles -> RECOVER, `result` unchanged.
- RECOVER:
  - `if_rst`=1 for exactly RECOVER_CYCLES consecutive cycles, then 0.
  - Then go to IDLE with `irq`.
  - This state is needed because IF_stage FTI/MIS do not observe enable.
- `irq` asserts on the first IDLE cycle after DRAIN or RECOVER only.
- LFSR:
  - 16-bit Galois, mask 16'hB400. Shifts right, XORing the mask when the shifted-out bit is 1.
  - Advances once per cycle in RUN only; holds otherwise.
- `result`, `run_cycles` and `mis_cycles` stay sticky in IDLE until the next ARM.
- Async reset mid-run returns every output to its reset value immediately; no `irq` is generated.

Test Plan:
- Config write 16'h0A05 (pc_limit=10, freq=0, count=5), then start. Stub IF_stage asserts `irst_done` after 40 RUN cycles, `write_en` for 12 of them, and drops `irst_done` 1 cycle after enable falls.
  - Required: `irst_reg_data`=16'h8A05 from ARM; `result`=01, `run_cycles`=40, `mis_cycles`=12; exactly one `irq`; `if_rst` never asserted.
- Timeout=100, `irst_done` held 0 -> `result`=10 after exactly 100 RUN cycles; `if_rst` high for 2 cycles; `irq`; enable low from the RECOVER entry cycle.
- Abort written on the 5th RUN cycle -> `result`=11, `run_cycles`=5, RECOVER entered. Separately: a write with start and abort both set from IDLE stays IDLE with no `irq`.
- Seed write 0, then start -> lfsr=16'hACE1 in ARM; `rand_data` sequence over the first 4 RUN cycles matches the Galois 16'hB400 reference model. Config/timeout writes while busy leave the stored values unchanged.
- `irst_done` and timeout in the same cycle -> `result`=01 via DRAIN. `irst_done` held high for more than 8 DRAIN cycles -> RECOVER, `result` stays 01.
- `rst` driven low mid-RUN -> all outputs at reset values asynchronously (`irst_reg_data`=0, `busy`=0); no `irq` after release.

Source files
------------

// File: rtl/irst_sequencer.sv
// Run controller for IF-stage fault injection: holds the host IRST configuration, arms the
// fetch stage, counts run/MIS cycles, handles timeout and abort, and resets IF_stage on recovery.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; results from the last run stay visible
// ARM     | one cycle: counters cleared, LFSR seeded, enable raised
// RUN     | injection active; counters and LFSR advance every cycle
// DRAIN   | enable dropped, waiting for IF_stage to clear DONE
// RECOVER | if_rst pulsed because IF_stage cannot leave the run alone
module irst_sequencer #(
    parameter logic [15:0] SEED_DEFAULT    = 16'hACE1,
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'd0,
    parameter int unsigned RECOVER_CYCLES  = 2,
    parameter int unsigned DRAIN_MAX       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_en,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        irst_done,
    input  logic        write_en,
    output logic [15:0] irst_reg_data,
    output logic [2:0]  rand_data,
    output logic        if_rst,
    output logic        busy,
    output logic [1:0]  result,
    output logic [15:0] run_cycles,
    output logic [15:0] mis_cycles,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_RECOVER
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [7:0]  DRAIN_LOAD   = 8'(DRAIN_MAX - 1);
    localparam logic [7:0]  RECOVER_LOAD = 8'(RECOVER_CYCLES - 1);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_ABORT   = 2'b11;

    state_t      state_q;
    logic [14:0] cfg_q;
    logic [15:0] seed_q;
    logic [15:0] timeout_q;
    logic [15:0] lfsr_q;
    logic [15:0] run_q;
    logic [15:0] mis_q;
    logic [1:0]  result_q;
    logic        irq_q;
    logic [7:0]  tmr_q;

    logic [15:0] lfsr_d;
    logic [15:0] run_d;
    logic [15:0] mis_d;
    logic        cmd_wr;
    logic        cmd_start;
    logic        cmd_abort;
    logic        timeout_hit;

    // Abort takes precedence over start when both bits arrive in one write.
    assign cmd_wr    = cfg_wr_en && (cfg_addr == 2'd3);
    assign cmd_abort = cmd_wr && cfg_wdata[1];
    assign cmd_start = cmd_wr && cfg_wdata[0] && !cfg_wdata[1];

    assign lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign run_d       = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
    assign mis_d       = (write_en && (mis_q != 16'hFFFF)) ? mis_q + 16'd1 : mis_q;
    assign timeout_hit = (timeout_q != 16'd0) && (run_q == timeout_q - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            seed_q    <= SEED_DEFAULT;
            timeout_q <= TIMEOUT_DEFAULT;
            lfsr_q    <= SEED_DEFAULT;
            run_q     <= '0;
            mis_q     <= '0;
            result_q  <= RES_NONE;
            irq_q     <= 1'b0;
            tmr_q     <= '0;
        end else begin
            irq_q <= 1'b0;

            if (cfg_wr_en && (state_q == S_IDLE)) begin
                case (cfg_addr)
                    2'd0:    cfg_q     <= cfg_wdata[14:0];
                    2'd1:    seed_q    <= (cfg_wdata == 16'd0) ? SEED_DEFAULT : cfg_wdata;
                    2'd2:    timeout_q <= cfg_wdata;
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        state_q  <= S_ARM;
                        run_q    <= '0;
                        mis_q    <= '0;
                        result_q <= RES_NONE;
                        lfsr_q   <= seed_q;
                    end
                end
                S_ARM: begin
                    if (cmd_abort) begin
                        state_q  <= S_RECOVER;
                        result_q <= RES_ABORT;
                        tmr_q    <= RECOVER_LOAD;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    run_q  <= run_d;
                    mis_q  <= mis_d;
                    lfsr_q <= lfsr_d;
                    if (irst_done) begin
                        state_q  <= S_DRAIN;
                        result_q <= RES_PASS;
                        tmr_q    <= DRAIN_LOAD;
                    end else if (cmd_abort) begin
                        state_q  <= S_RECOVER;
                        result_q <= RES_ABORT;
                        tmr_q    <= RECOVER_LOAD;
                    end else if (timeout_hit) begin
                        state_q  <= S_RECOVER;
                        result_q <= RES_TIMEOUT;
                        tmr_q    <= RECOVER_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (!irst_done) begin
                        state_q <= S_IDLE;
                        irq_q   <= 1'b1;
                    end else if (tmr_q == 8'd0) begin
                        state_q <= S_RECOVER;
                        tmr_q   <= RECOVER_LOAD;
                    end else begin
                        tmr_q <= tmr_q - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (tmr_q == 8'd0) begin
                        state_q <= S_IDLE;
                        irq_q   <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign irst_reg_data = {(state_q == S_ARM) || (state_q == S_RUN), cfg_q};
    assign rand_data     = lfsr_q[2:0];
    assign if_rst        = (state_q == S_RECOVER);
    assign busy          = (state_q != S_IDLE);
    assign result        = result_q;
    assign run_cycles    = run_q;
    assign mis_cycles    = mis_q;
    assign irq           = irq_q;

endmodule
